gate_chain_pipe: RTL and testbench



---
 rtl/gate_chain_pkg.sv | 24 ++
 rtl/gate_chain_stage.sv | 74 +++++++
 rtl/gate_chain_pipe.sv | 88 ++++++++
 tb/tb_gate_chain_pipe.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/gate_chain_pkg.sv
// gate_chain_pkg: gate-mode encodings and the per-bit gate function shared by
// every stage of gate_chain_pipe.
package gate_chain_pkg;

    typedef enum logic [1:0] {
        MODE_NOR  = 2'b00,
        MODE_NAND = 2'b01,
        MODE_XOR  = 2'b10,
        MODE_XNOR = 2'b11
    } gate_mode_e;

    // One bit of the selected two-input gate; stages apply it lane by lane.
    function automatic logic gate_fn(input logic [1:0] mode, input logic a, input logic b);
        logic r;
        case (mode)
            MODE_NOR:  r = ~(a | b);
            MODE_NAND: r = ~(a & b);
            MODE_XOR:  r = a ^ b;
            default:   r = ~(a ^ b);
        endcase
        return r;
    endfunction

endpackage

// File: rtl/gate_chain_stage.sv
// gate_chain_stage: one gate of the cascade plus its register slice.
// Stage IDX combines the upstream running tap with op IDX, records the
// result into lane IDX of the tap vector and carries the operand set onward.
// With GATE_CHAIN_MODE_EN defined, the gate mode travels with the set;
// otherwise the mode register is absent and the gate is always NOR.
module gate_chain_stage
    import gate_chain_pkg::*;
#(
    parameter int STAGES = 3,
    parameter int W      = 1,
    parameter int IDX    = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  vld_in,
    input  logic [W-1:0]          tap_in,
    input  logic [STAGES*W-1:0]   taps_in,
    input  logic [STAGES*W-1:0]   ops_in,
`ifdef GATE_CHAIN_MODE_EN
    input  logic [1:0]            mode_in,
    output logic [1:0]            mode_q,
`endif
    output logic                  vld_q,
    output logic [W-1:0]          tap_q,
    output logic [STAGES*W-1:0]   taps_q,
    output logic [STAGES*W-1:0]   ops_q
);

    localparam logic [STAGES*W-1:0] LANE = (STAGES*W)'({W{1'b1}});

    logic [1:0]          mode_cur;
    logic [W-1:0]        tap_nxt;
    logic [STAGES*W-1:0] taps_nxt;

`ifdef GATE_CHAIN_MODE_EN
    assign mode_cur = mode_in;
`else
    assign mode_cur = MODE_NOR;
`endif

    // Gate this stage's lane and splice it into the tap vector.
    always_comb begin
        tap_nxt = '0;
        for (int b = 0; b < W; b++)
            tap_nxt[b] = gate_fn(mode_cur, tap_in[b], ops_in[IDX*W + b]);
        taps_nxt = (taps_in & ~(LANE << (IDX*W))) | ((STAGES*W)'(tap_nxt) << (IDX*W));
    end

    // Slice register: valid follows the enable, data only loads with a real set
    // so the outputs stay quiet while bubbles pass.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q  <= 1'b0;
            tap_q  <= '0;
            taps_q <= '0;
            ops_q  <= '0;
`ifdef GATE_CHAIN_MODE_EN
            mode_q <= MODE_NOR;
`endif
        end else if (en) begin
            vld_q <= vld_in;
            if (vld_in) begin
                tap_q  <= tap_nxt;
                taps_q <= taps_nxt;
                ops_q  <= ops_in;
`ifdef GATE_CHAIN_MODE_EN
                mode_q <= mode_in;
`endif
            end
        end
    end

endmodule

// File: rtl/gate_chain_pipe.sv
// gate_chain_pipe: pipelined cascade of STAGES two-input gates with valid/ready
// on both sides. tap0 = f(seed, op0), tapk = f(tap(k-1), opk); all taps exposed.
// Optional feature macro: GATE_CHAIN_MODE_EN adds the op_mode port (NOR, NAND,
// XOR, XNOR per set). Without it every stage is NOR.
module gate_chain_pipe
    import gate_chain_pkg::*;
#(
    parameter int STAGES = 3,
    parameter int W      = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [W-1:0]          in_seed,
    input  logic [STAGES*W-1:0]   in_ops,
`ifdef GATE_CHAIN_MODE_EN
    input  logic [1:0]            op_mode,
`endif
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [STAGES*W-1:0]   out_taps,
    output logic [W-1:0]          out_last
);

    // Index 0 is the upstream side; index k+1 is the output of stage k.
    logic [STAGES:0]                 vld_pipe;
    logic [STAGES:0]                 en;
    logic [STAGES:0][W-1:0]          tap_pipe;
    logic [STAGES:0][STAGES*W-1:0]   taps_pipe;
    logic [STAGES:0][STAGES*W-1:0]   ops_pipe;
`ifdef GATE_CHAIN_MODE_EN
    logic [STAGES:0][1:0]            mode_pipe;
    assign mode_pipe[0] = op_mode;
`endif

    assign vld_pipe[0]  = in_valid;
    assign tap_pipe[0]  = in_seed;
    assign taps_pipe[0] = '0;
    assign ops_pipe[0]  = in_ops;

    // Ready ripples back from the sink: a slice may load if it is empty or
    // its own contents move on this cycle. Only slice valids and out_ready feed it.
    always_comb begin
        en = '0;
        en[STAGES] = out_ready;
        for (int k = STAGES-1; k >= 0; k--)
            en[k] = !vld_pipe[k+1] || en[k+1];
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        gate_chain_stage #(
            .STAGES (STAGES),
            .W      (W),
            .IDX    (k)
        ) u_stage (
            .clk     (clk),
            .rst     (rst),
            .en      (en[k]),
            .vld_in  (vld_pipe[k]),
            .tap_in  (tap_pipe[k]),
            .taps_in (taps_pipe[k]),
            .ops_in  (ops_pipe[k]),
`ifdef GATE_CHAIN_MODE_EN
            .mode_in (mode_pipe[k]),
            .mode_q  (mode_pipe[k+1]),
`endif
            .vld_q   (vld_pipe[k+1]),
            .tap_q   (tap_pipe[k+1]),
            .taps_q  (taps_pipe[k+1]),
            .ops_q   (ops_pipe[k+1])
        );
    end

    assign in_ready  = en[0];
    assign out_valid = vld_pipe[STAGES];
    assign out_taps  = taps_pipe[STAGES];
    assign out_last  = tap_pipe[STAGES];

    // Operands and mode leaving the last slice have no consumer.
    logic unused_tail;
`ifdef GATE_CHAIN_MODE_EN
    assign unused_tail = ^{ops_pipe[STAGES], mode_pipe[STAGES]};
`else
    assign unused_tail = ^ops_pipe[STAGES];
`endif

endmodule

// File: tb/tb_gate_chain_pipe.sv
// tb_gate_chain_pipe: directed checks of gate_chain_pipe with STAGES=3, W=4.
module tb_gate_chain_pipe;

    localparam int STAGES = 3;
    localparam int W      = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [W-1:0]      in_seed;
    logic [STAGES*W-1:0] in_ops;
    logic [1:0]        cur_mode;
    logic              out_valid;
    logic              out_ready;
    logic [STAGES*W-1:0] out_taps;
    logic [W-1:0]      out_last;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int n_out  = 0;
    int first_cyc, last_cyc;
    logic [11:0] exp_q[$];

    gate_chain_pipe #(.STAGES(STAGES), .W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_seed   (in_seed),
        .in_ops    (in_ops),
`ifdef GATE_CHAIN_MODE_EN
        .op_mode   (cur_mode),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_taps  (out_taps),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Small reference: bitwise gate chain for a 3-stage, 4-bit set.
    function automatic logic [11:0] ref_taps(input logic [1:0] m, input logic [3:0] s, input logic [11:0] o);
        logic [3:0]  t;
        logic [11:0] r;
        t = s;
        r = '0;
        for (int k = 0; k < 3; k++) begin
            case (m)
                2'b00:   t = ~(t | o[k*4 +: 4]);
                2'b01:   t = ~(t & o[k*4 +: 4]);
                2'b10:   t = t ^ o[k*4 +: 4];
                default: t = ~(t ^ o[k*4 +: 4]);
            endcase
            r[k*4 +: 4] = t;
        end
        return r;
    endfunction

    function automatic logic [3:0]  vec_seed(input int i); return 4'(i*5 + 3); endfunction
    function automatic logic [11:0] vec_ops(input int i);  return 12'(i*12'h3A7 + 12'h1C9); endfunction

    // One cycle from a negedge: record handshakes seen with the inputs already
    // applied, score any delivered result, then move to the next negedge.
    task automatic step(input logic [11:0] exp_in, output logic acc);
        logic [11:0] e;
        #1;
        acc = in_valid && in_ready;
        if (acc) exp_q.push_back(exp_in);
        if (out_valid && out_ready) begin
            n_out++;
            if (n_out == 1) first_cyc = cyc;
            last_cyc = cyc;
            if (exp_q.size() == 0) chk("spurious_out", 64'(exp_q.size()), 64'd1);
            else begin
                e = exp_q.pop_front();
                chk("out_taps", out_taps, e);
                chk("out_last", out_last, e[11:8]);
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic drain();
        logic acc;
        in_valid = 1'b0;
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) step('0, acc);
        chk("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        logic        acc;
        logic        held;
        logic [11:0] held_taps;
        int          idx;

        rst = 1'b1; in_valid = 1'b0; in_seed = '0; in_ops = '0;
        cur_mode = 2'b00; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_taps", out_taps, 0);
        chk("rst_out_last", out_last, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);

        // NOR latency: seed 0, ops {0,F,0} -> taps F0F.
        in_valid = 1'b1; in_seed = 4'h0; in_ops = 12'h0F0;
        #1 chk("lat_in_ready", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        chk("lat_edge1", out_valid, 0);
        @(negedge clk);
        chk("lat_edge2", out_valid, 0);
        @(negedge clk);
        chk("lat_edge3_valid", out_valid, 1);
        chk("lat_taps", out_taps, 12'hF0F);
        chk("lat_last", out_last, 4'hF);
        @(negedge clk);
        chk("lat_drained", out_valid, 0);

        // NOR: seed 5, ops {F,8,3} -> taps 078.
        in_valid = 1'b1; in_seed = 4'h5; in_ops = 12'hF83;
        step(12'h078, acc);
        drain();

`ifdef GATE_CHAIN_MODE_EN
        // NAND: seed F, ops {0,F,A} -> taps FA5.
        cur_mode = 2'b01; in_valid = 1'b1; in_seed = 4'hF; in_ops = 12'h0FA;
        step(12'hFA5, acc);
        drain();
        // Mixed modes back to back: seed 6, ops {C,5,3}.
        in_valid = 1'b1; in_seed = 4'h6; in_ops = 12'hC53;
        cur_mode = 2'b00; step(12'h128, acc);
        cur_mode = 2'b10; step(12'hC05, acc);
        cur_mode = 2'b11; step(12'h30A, acc);
        drain();
        cur_mode = 2'b00;
`endif

        // Back-to-back: 8 sets, sink always ready.
        n_out = 0;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; in_seed = vec_seed(i); in_ops = vec_ops(i);
            #1 chk("b2b_in_ready", in_ready, 1);
            step(ref_taps(cur_mode, vec_seed(i), vec_ops(i)), acc);
        end
        drain();
        chk("b2b_count", 64'(n_out), 64'd8);
        chk("b2b_span", 64'(last_cyc - first_cyc), 64'd7);

        // Stall: sink blocked for 5 cycles while a 6-set stream is offered.
        n_out = 0; idx = 0; held = 1'b0; held_taps = '0;
        for (int c = 0; c < 40 && !(idx == 6 && exp_q.size() == 0); c++) begin
            out_ready = (c >= 5);
            if (idx < 6) begin
                in_valid = 1'b1; in_seed = vec_seed(idx + 20); in_ops = vec_ops(idx + 20);
            end else in_valid = 1'b0;
            #1;
            if (c == 3 || c == 4) chk("stall_in_ready", in_ready, 0);
            if (c == 5) chk("release_in_ready", in_ready, 1);
            if (out_valid && !out_ready) begin
                if (held) chk("stall_hold", out_taps, held_taps);
                held = 1'b1; held_taps = out_taps;
            end else held = 1'b0;
            step(ref_taps(cur_mode, vec_seed(idx + 20), vec_ops(idx + 20)), acc);
            if (acc) idx++;
        end
        chk("stall_sent", 64'(idx), 64'd6);
        chk("stall_count", 64'(n_out), 64'd6);
        out_ready = 1'b1;

        // Reset with two sets in flight, one of them presented at the output.
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; in_seed = vec_seed(i + 40); in_ops = vec_ops(i + 40);
            step('0, acc);
        end
        in_valid = 1'b0;
        step('0, acc);
        chk("rst_pre_valid", out_valid, 1);
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_out_taps", out_taps, 0);
        chk("midrst_out_last", out_last, 0);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", in_ready, 1);
        n_out = 0;
        in_valid = 1'b1; in_seed = 4'h0; in_ops = 12'h0F0;
        step(12'hF0F, acc);
        drain();
        chk("post_rst_count", 64'(n_out), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Absolute guard so the run always ends.
    initial begin
        #200000;
        errors++;
        $display("FAIL timeout: simulation did not finish");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1);
    end

endmodule
